// File: rtl/div_pkg.sv
// Shared widths and FSM state type for the 8-by-4 restoring divider.
package div_pkg;

  localparam int unsigned DVD_W = 8;
  localparam int unsigned DVS_W = 4;
  localparam int unsigned REM_W = 5;
  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, then subtract the divisor if it fits.
module div_step
  import div_pkg::*;
(
  input  logic [REM_W-1:0] r,
  input  logic             bit_in,
  input  logic [DVS_W-1:0] divisor,
  output logic [REM_W-1:0] r_next,
  output logic             q_bit
);

  logic [REM_W-1:0] r_shift;
  logic [REM_W-1:0] dvs_ext;

  // R stays below the divisor between steps, so its MSB never reaches the shifted value.
  logic unused_r_msb;
  assign unused_r_msb = r[REM_W-1];

  always_comb begin
    r_shift = {r[REM_W-2:0], bit_in};
    dvs_ext = {1'b0, divisor};
    q_bit   = (r_shift >= dvs_ext);
    r_next  = q_bit ? (r_shift - dvs_ext) : r_shift;
  end

endmodule

// File: rtl/restoring_divider_8x4.sv
// Unsigned 8/4 restoring divider, one quotient bit per cycle, fixed 9-cycle latency.
// Optional DIV_ZERO_CHECK_EN short-circuits a zero divisor and flags it on div_by_zero.
module restoring_divider_8x4
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder
`ifdef DIV_ZERO_CHECK_EN
  ,
  output logic             div_by_zero
`endif
);

  state_e           state_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DVS_W-1:0] dvs_q;
  logic [REM_W-1:0] r_q;
  logic [CNT_W-1:0] cnt_q;
  logic [REM_W-1:0] r_next;
  logic             q_bit;

  div_step u_step (
    .r       (r_q),
    .bit_in  (dvd_q[DVD_W-1]),
    .divisor (dvs_q),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            r_q   <= '0;
            cnt_q <= '0;
            busy  <= 1'b1;
`ifdef DIV_ZERO_CHECK_EN
            if (divisor == '0) begin
              state_q     <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[DVS_W-1:0];
            end else begin
              state_q     <= RUN;
              div_by_zero <= 1'b0;
            end
`else
            state_q <= RUN;
`endif
          end
        end
        RUN: begin
          // The dividend register doubles as the quotient accumulator.
          r_q   <= r_next;
          dvd_q <= {dvd_q[DVD_W-2:0], q_bit};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DVD_W - 1)) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
`ifdef DIV_ZERO_CHECK_EN
          // A zero-divisor result was already published on entry to DONE.
          if (!div_by_zero) begin
            done      <= 1'b1;
            quotient  <= dvd_q;
            remainder <= r_q[DVS_W-1:0];
          end
`else
          done      <= 1'b1;
          quotient  <= dvd_q;
          remainder <= r_q[DVS_W-1:0];
`endif
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/restoring_divider_8x4.md
RESTORING_DIVIDER_8X4 -- requirements
Module: restoring_divider_8x4

Interface
REQ-001 Parameters SHALL be none; widths are fixed at an 8-bit dividend, 4-bit divisor, 8-bit quotient and 4-bit remainder.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 dividend  input  8  unsigned dividend; captured on the accepted start.
REQ-007 divisor  input  4  unsigned divisor; captured on the accepted start.
REQ-008 busy  output  1  high while a division is in progress (RUN or DONE).
REQ-009 done  output  1  one-cycle pulse marking that quotient and remainder are valid.
REQ-010 quotient  output  8  registered result.
REQ-011 remainder  output  4  registered result.
REQ-012 div_by_zero  output  1  present only with DIV_ZERO_CHECK_EN; flags a zero divisor.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 Transitions SHALL be: IDLE->RUN on start; RUN->DONE after the 8th iteration; DONE->IDLE unconditionally.
REQ-015 Start SHALL be accepted only in IDLE and ignored in RUN and DONE, with no queuing.
REQ-016 On acceptance the block SHALL capture the operands, clear the 5-bit partial remainder R, and clear the 3-bit iteration counter.
REQ-017 Each RUN cycle SHALL process one dividend bit, MSB first, by restoring division.
REQ-018 Each iteration SHALL compute R' = {R[3:0], next dividend bit}.
REQ-019 If R' >= {1'b0, divisor}, then R = R' - divisor and the quotient bit is 1; otherwise R = R' and the quotient bit is 0.
REQ-020 Latency SHALL be fixed: a start sampled at edge N yields done high for exactly the cycle after edge N+9, with results updated at that same edge.
REQ-021 Latency SHALL be independent of operand values.
REQ-022 Quotient and remainder SHALL hold their values until the next completion and SHALL NOT change during RUN.
REQ-023 A zero divisor without the macro SHALL run the normal 9-cycle algorithm, giving quotient = 8'hFF and remainder = dividend[3:0].
REQ-024 A dividend smaller than the divisor SHALL give quotient = 0 and remainder = dividend[3:0].
REQ-025 Arithmetic SHALL be unsigned, and no intermediate SHALL exceed 5 bits.
REQ-026 busy SHALL deassert in the same cycle the FSM returns to IDLE, so a new start is accepted on the cycle immediately after the done cycle.

Reset
REQ-027 When rst is high at a clock edge, state SHALL go to IDLE and busy, done, quotient, remainder, the counter, R and div_by_zero SHALL all be 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation, with no done pulse and results cleared.
REQ-029 rst SHALL take priority over start in the same cycle.

Configuration
REQ-030 The macro DIV_ZERO_CHECK_EN SHALL control the zero-divisor feature.
REQ-031 When DIV_ZERO_CHECK_EN is defined, an accepted start with divisor = 0 SHALL skip RUN and go IDLE->DONE.
REQ-032 In that case, done and div_by_zero SHALL be high in the cycle after the start edge, with quotient = 8'hFF and remainder = dividend[3:0].
REQ-033 div_by_zero SHALL be cleared at the next accepted start and otherwise held.
REQ-034 When DIV_ZERO_CHECK_EN is undefined, the div_by_zero port and its logic SHALL be absent, and REQ-023 applies.

Structure
REQ-035 Package div_pkg SHALL hold DVD_W=8, DVS_W=4, REM_W=5, CNT_W=3 and the state enum {IDLE, RUN, DONE}.
REQ-036 One combinational sub-module, div_step, SHALL implement a single compare/subtract/shift iteration (in: R, bit, divisor; out: new R, quotient bit), instanced once.

Verification
REQ-037 dividend=225, divisor=15, start -> done after 9 cycles; quotient=15, remainder=0.
REQ-038 dividend=200, divisor=7 -> quotient=28, remainder=4; outputs stable through 5 further idle cycles.
REQ-039 dividend=7, divisor=9 -> quotient=0, remainder=7; then start held high continuously -> back-to-back operations, each done 10 cycles apart.
REQ-040 dividend=8'hA5, divisor=0 -> quotient=8'hFF, remainder=5; with DIV_ZERO_CHECK_EN, done and div_by_zero are high 1 cycle after start; without it, done comes after 9 cycles.
REQ-041 A start pulse in RUN with new operands (e.g., 255/1) is ignored; the original operation's result is unaffected.
REQ-042 rst asserted 4 cycles into RUN -> next cycle busy=0, quotient=0, remainder=0, and no done pulse.
